// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: bundles the processor writeback, host request and
// regfile write-port signals of the register-file write arbiter.
// The master modport is the requester/regfile side and the slave modport is
// the arbiter itself.
interface regfile_wr_arbiter_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          proc_we;
  logic [4:0]    proc_reg;
  logic [31:0]   proc_data;
  logic          proc_stall;
  logic          host_valid;
  logic [4:0]    host_reg;
  logic [31:0]   host_data;
  logic          host_ready;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic [CW-1:0] fifo_count;
  logic          wr_err;

  modport master (
    output proc_we, proc_reg, proc_data, host_valid, host_reg, host_data,
    input  proc_stall, host_ready, ctrl_writeEnable, ctrl_writeReg,
           data_writeReg, fifo_count, wr_err
  );

  modport slave (
    input  proc_we, proc_reg, proc_data, host_valid, host_reg, host_data,
    output proc_stall, host_ready, ctrl_writeEnable, ctrl_writeReg,
           data_writeReg, fifo_count, wr_err
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port between processor
// writeback (priority) and a FIFO-buffered host requester. An aging counter
// on the FIFO head forces a one-cycle processor stall so host writes cannot
// starve. Write controls to the regfile are driven from flops.
// Optional feature macro: REGFILE_WR_PROTECT_EN -- writes to registers whose
// bit is set in PROT_MASK are consumed but suppressed and set sticky wr_err.
module regfile_wr_arbiter #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_WAIT  = 8,
  parameter logic [31:0] PROT_MASK = 32'h00F0_003F
) (
  input logic                 clock,
  input logic                 ctrl_reset,
  regfile_wr_arbiter_if.slave bus
);
  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]     MAX_AGE = 8'(MAX_WAIT);

  // Register 0 is never written; with protection the mask adds more targets.
`ifdef REGFILE_WR_PROTECT_EN
  localparam logic [31:0] SUPPRESS_MASK = PROT_MASK | 32'h0000_0001;
`else
  localparam logic [31:0] SUPPRESS_MASK = (PROT_MASK & 32'h0000_0000) | 32'h0000_0001;
`endif

  // Host FIFO storage and pointers
  logic [4:0]    mem_reg_q  [DEPTH];
  logic [4:0]    mem_reg_d  [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    age_q, age_d;

  // Registered regfile write port and sticky error
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  // Arbitration results
  logic          force_s;
  logic          host_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          grant_s;
  logic          suppress_s;
  logic [4:0]    gnt_reg_s;
  logic [31:0]   gnt_data_s;
  logic [31:0]   supp_mask_s;

  assign supp_mask_s  = SUPPRESS_MASK;
  // Both depend on flops only, so the requesters see no input-to-output path.
  assign force_s      = (age_q == MAX_AGE) && (count_q != '0);
  assign host_ready_s = (count_q < DEPTH_C);
  assign push_s       = bus.host_valid && host_ready_s;

  // Priority arbitration: forced host grant, then processor, then host.
  always_comb begin
    pop_s      = 1'b0;
    grant_s    = 1'b0;
    gnt_reg_s  = bus.proc_reg;
    gnt_data_s = bus.proc_data;
    if (force_s) begin
      pop_s      = 1'b1;
      grant_s    = 1'b1;
      gnt_reg_s  = mem_reg_q[rd_ptr_q];
      gnt_data_s = mem_data_q[rd_ptr_q];
    end else if (bus.proc_we) begin
      grant_s    = 1'b1;
    end else if (count_q != '0) begin
      pop_s      = 1'b1;
      grant_s    = 1'b1;
      gnt_reg_s  = mem_reg_q[rd_ptr_q];
      gnt_data_s = mem_data_q[rd_ptr_q];
    end else begin
      grant_s    = 1'b0;
    end
    suppress_s = supp_mask_s[gnt_reg_s];
  end

  // FIFO next state: write on push, advance read pointer on pop, track count.
  always_comb begin
    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      mem_reg_d[wr_ptr_q]  = bus.host_reg;
      mem_data_d[wr_ptr_q] = bus.host_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d             = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Head aging: restart for each new head, saturate at MAX_WAIT.
  always_comb begin
    age_d = age_q;
    if (pop_s || (count_q == '0)) begin
      age_d = 8'd0;
    end else if (age_q != MAX_AGE) begin
      age_d = age_q + 8'd1;
    end else begin
      age_d = age_q;
    end
  end

  // Output stage: pulse write enable on a real write, otherwise hold reg/data.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant_s && !suppress_s) begin
      we_d    = 1'b1;
      wreg_d  = gnt_reg_s;
      wdata_d = gnt_data_s;
    end else begin
      we_d    = 1'b0;
    end
`ifdef REGFILE_WR_PROTECT_EN
    err_d = err_q | (grant_s & PROT_MASK[gnt_reg_s]);
`else
    err_d = 1'b0;
`endif
  end

  // State registers with asynchronous flush of FIFO and output stage.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg_q[i]  <= 5'd0;
        mem_data_q[i] <= 32'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= 8'd0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      mem_reg_q  <= mem_reg_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.proc_stall       = force_s;
  assign bus.host_ready       = host_ready_s;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
  assign bus.fifo_count       = count_q;
  assign bus.wr_err           = err_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scenario tasks for regfile_wr_arbiter. Expected
// regfile writes are queued when stimulus is driven and matched against the
// write port once per cycle; processor and host writes use disjoint registers.
module tb_regfile_wr_arbiter;
  logic clock = 1'b0;
  logic ctrl_reset;
  int   errors = 0;
  int   checks = 0;
  logic [36:0] proc_q [$];
  logic [36:0] host_q [$];

  always #5 clock = ~clock;

  regfile_wr_arbiter_if #(.DEPTH(4)) bus ();

  regfile_wr_arbiter #(
    .DEPTH(4), .MAX_WAIT(8), .PROT_MASK(32'h00F0_003F)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus)
  );

  // Match any write on the port against the queue of its requester.
  task automatic sb_compare();
    logic [36:0] got;
    logic [36:0] exp;
    @(negedge clock);
    if (!ctrl_reset && bus.ctrl_writeEnable === 1'b1) begin
      got = {bus.ctrl_writeReg, bus.data_writeReg};
      checks++;
      if (bus.ctrl_writeReg == 5'd6 || bus.ctrl_writeReg >= 5'd16) begin
        if (proc_q.size() == 0) begin
          errors++;
          $display("FAIL sb_proc_write: got reg=%0d data=%h, required no write", got[36:32], got[31:0]);
        end else begin
          exp = proc_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_proc_write: got reg=%0d data=%h, required reg=%0d data=%h", got[36:32], got[31:0], exp[36:32], exp[31:0]);
          end
        end
      end else begin
        if (host_q.size() == 0) begin
          errors++;
          $display("FAIL sb_host_write: got reg=%0d data=%h, required no write", got[36:32], got[31:0]);
        end else begin
          exp = host_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_host_write: got reg=%0d data=%h, required reg=%0d data=%h", got[36:32], got[31:0], exp[36:32], exp[31:0]);
          end
        end
      end
    end
  endtask

  task automatic tick();
    sb_compare();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset     = 1'b1;
    bus.proc_we    = 1'b0;
    bus.proc_reg   = 5'd0;
    bus.proc_data  = 32'd0;
    bus.host_valid = 1'b0;
    bus.host_reg   = 5'd0;
    bus.host_data  = 32'd0;
    #1;
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", bus.ctrl_writeEnable); end
    checks++; if (bus.ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d, required 0", bus.ctrl_writeReg); end
    checks++; if (bus.data_writeReg !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h, required 0", bus.data_writeReg); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", bus.wr_err); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", bus.fifo_count); end
    checks++; if (bus.proc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", bus.proc_stall); end
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus.host_ready); end
    tick();
    tick();
    ctrl_reset = 1'b0;
    tick();
  endtask

  task automatic test_proc_path();
    bus.proc_we   = 1'b1;
    bus.proc_reg  = 5'd6;
    bus.proc_data = 32'h0000_1234;
    proc_q.push_back({5'd6, 32'h0000_1234});
    tick();
    bus.proc_we = 1'b0;
    checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd6 || bus.data_writeReg !== 32'h0000_1234) begin
      errors++; $display("FAIL proc_write: got we=%b reg=%0d data=%h, required we=1 reg=6 data=00001234", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg);
    end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL proc_we_drop: got %b, required 0", bus.ctrl_writeEnable); end
  endtask

  task automatic test_idle_host();
    bus.host_valid = 1'b1;
    bus.host_reg   = 5'd13;
    bus.host_data  = 32'h0000_00AA;
    host_q.push_back({5'd13, 32'h0000_00AA});
    tick();
    bus.host_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd1 || bus.ctrl_writeEnable !== 1'b0) begin
      errors++; $display("FAIL host_accept: got count=%0d we=%b, required count=1 we=0", bus.fifo_count, bus.ctrl_writeEnable);
    end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd13 || bus.data_writeReg !== 32'h0000_00AA || bus.fifo_count !== 3'd0) begin
      errors++; $display("FAIL host_write: got we=%b reg=%0d data=%h count=%0d, required we=1 reg=13 data=000000aa count=0", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, bus.fifo_count);
    end
    bus.host_valid = 1'b1;
    bus.host_reg   = 5'd7;
    bus.host_data  = 32'h0000_0077;
    host_q.push_back({5'd7, 32'h0000_0077});
    tick();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL pushpop_pre: got count=%0d, required 1", bus.fifo_count); end
    bus.host_reg  = 5'd8;
    bus.host_data = 32'h0000_0088;
    host_q.push_back({5'd8, 32'h0000_0088});
    tick();
    bus.host_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL pushpop_same: got count=%0d, required 1", bus.fifo_count); end
    tick();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL pushpop_drain: got count=%0d, required 0", bus.fifo_count); end
    tick();
  endtask

  task automatic test_starvation();
    int   n;
    logic stall_before;
    int   stall_k [$];
    n = 0;
    bus.proc_we    = 1'b1;
    bus.proc_reg   = 5'(24 + (n % 8));
    bus.proc_data  = 32'hC000_0000 + 32'(n);
    proc_q.push_back({bus.proc_reg, bus.proc_data});
    n++;
    bus.host_valid = 1'b1;
    bus.host_reg   = 5'd11;
    bus.host_data  = 32'hB000_0011;
    host_q.push_back({5'd11, 32'hB000_0011});
    for (int k = 1; k <= 46; k++) begin
      stall_before = bus.proc_stall;
      tick();
      if (k < 4) begin
        bus.host_reg  = 5'(11 + k);
        bus.host_data = 32'hB000_0011 + 32'(k);
        host_q.push_back({bus.host_reg, bus.host_data});
      end else if (k == 4) begin
        bus.host_valid = 1'b0;
        checks++; if (bus.host_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
          errors++; $display("FAIL starve_full: got ready=%b count=%0d, required ready=0 count=4", bus.host_ready, bus.fifo_count);
        end
      end
      if (bus.proc_stall === 1'b1) stall_k.push_back(k);
      if (stall_before !== 1'b1) begin
        if (k < 46) begin
          bus.proc_reg  = 5'(24 + (n % 8));
          bus.proc_data = 32'hC000_0000 + 32'(n);
          proc_q.push_back({bus.proc_reg, bus.proc_data});
          n++;
        end else begin
          bus.proc_we = 1'b0;
        end
      end
    end
    bus.proc_we = 1'b0;
    checks++; if (stall_k.size() != 4) begin errors++; $display("FAIL starve_stalls: got %0d stall cycles, required 4", stall_k.size()); end
    foreach (stall_k[i]) begin
      checks++; if (stall_k[i] != 9 * (i + 1)) begin
        errors++; $display("FAIL starve_stall_pos: got stall at cycle %0d, required %0d", stall_k[i], 9 * (i + 1));
      end
    end
    tick();
    tick();
    checks++; if (proc_q.size() != 0 || host_q.size() != 0 || bus.fifo_count !== 3'd0) begin
      errors++; $display("FAIL starve_drain: got pending proc=%0d host=%0d count=%0d, required 0 0 0", proc_q.size(), host_q.size(), bus.fifo_count);
    end
  endtask

  task automatic test_reg0();
    logic exp_err;
`ifdef REGFILE_WR_PROTECT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.proc_we   = 1'b1;
    bus.proc_reg  = 5'd0;
    bus.proc_data = 32'hDEAD_0000;
    tick();
    bus.proc_we = 1'b0;
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reg0_proc: got we=%b, required 0", bus.ctrl_writeEnable); end
    bus.host_valid = 1'b1;
    bus.host_reg   = 5'd0;
    bus.host_data  = 32'hDEAD_0001;
    tick();
    bus.host_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL reg0_push: got count=%0d, required 1", bus.fifo_count); end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b0 || bus.fifo_count !== 3'd0) begin
      errors++; $display("FAIL reg0_host: got we=%b count=%0d, required we=0 count=0", bus.ctrl_writeEnable, bus.fifo_count);
    end
    checks++; if (bus.wr_err !== exp_err) begin errors++; $display("FAIL reg0_err: got %b, required %b", bus.wr_err, exp_err); end
    tick();
  endtask

  task automatic test_protect();
    logic exp_we;
    logic exp_err;
`ifdef REGFILE_WR_PROTECT_EN
    exp_we  = 1'b0;
    exp_err = 1'b1;
`else
    exp_we  = 1'b1;
    exp_err = 1'b0;
    host_q.push_back({5'd3, 32'h0000_0005});
`endif
    bus.host_valid = 1'b1;
    bus.host_reg   = 5'd3;
    bus.host_data  = 32'h0000_0005;
    tick();
    bus.host_valid = 1'b0;
    tick();
    checks++; if (bus.ctrl_writeEnable !== exp_we) begin errors++; $display("FAIL prot_we: got %b, required %b", bus.ctrl_writeEnable, exp_we); end
    checks++; if (bus.wr_err !== exp_err) begin errors++; $display("FAIL prot_err: got %b, required %b", bus.wr_err, exp_err); end
    tick();
    tick();
    checks++; if (bus.wr_err !== exp_err) begin errors++; $display("FAIL prot_err_hold: got %b, required %b", bus.wr_err, exp_err); end
  endtask

  task automatic test_reset_midstream();
    bus.proc_we    = 1'b1;
    bus.proc_reg   = 5'd16;
    bus.host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.proc_data = 32'hD000_0000 + 32'(i);
      proc_q.push_back({5'd16, bus.proc_data});
      bus.host_reg  = 5'(9 + i);
      bus.host_data = 32'hE000_0000 + 32'(i);
      tick();
    end
    bus.proc_we    = 1'b0;
    bus.host_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL mid_fill: got count=%0d, required 3", bus.fifo_count); end
    sb_compare();
    #1;
    ctrl_reset = 1'b1;
    #1;
    checks++; if (bus.fifo_count !== 3'd0 || bus.ctrl_writeEnable !== 1'b0 || bus.host_ready !== 1'b1 || bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got count=%0d we=%b ready=%b err=%b, required 0 0 1 0", bus.fifo_count, bus.ctrl_writeEnable, bus.host_ready, bus.wr_err);
    end
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.fifo_count !== 3'd0 || bus.ctrl_writeEnable !== 1'b0) begin
      errors++; $display("FAIL mid_after: got count=%0d we=%b, required 0 0", bus.fifo_count, bus.ctrl_writeEnable);
    end
  endtask

  initial begin
    test_reset();
    test_proc_path();
    test_idle_host();
    test_starvation();
    test_reg0();
    test_protect();
    test_reset_midstream();
    tick();
    checks++; if (proc_q.size() != 0 || host_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got pending proc=%0d host=%0d, required 0 0", proc_q.size(), host_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port between processor writeback and a secondary host requester (debug/UART loader) that writes speed/direction and scratch registers at runtime. Processor writes have priority. Host writes are buffered in a small FIFO and protected from starvation by an aging counter that stalls the processor for one cycle when a host write has waited too long. The block drives the regfile's write controls through a registered output stage.

## Interface
- DEPTH, 4: host FIFO entries; must be a power of 2, ≥2.
- MAX_WAIT, 8: cycles a nonempty FIFO head may wait before forcing a grant; range 1–255.
- PROT_MASK, 32'h00F0003F: registers that reject writes (regs 0–5 and 20–23 are input-driven); used only under the macro.

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- proc_we  in  1  processor writeback request.
- proc_reg  in  5  processor destination register.
- proc_data  in  32  processor write data.
- proc_stall  out  1  processor must hold its writeback request and retry.
- host_valid  in  1  host write request.
- host_reg  in  5  host destination register.
- host_data  in  32  host write data.
- host_ready  out  1  FIFO can accept.
- ctrl_writeEnable  out  1  to regfile.
- ctrl_writeReg  out  5  to regfile.
- data_writeReg  out  32  to regfile.
- fifo_count  out  $clog2(DEPTH+1)  entries currently buffered.
- wr_err  out  1  sticky protected-write flag.

## Operation
- Host push: host_ready = (fifo_count < DEPTH), a pure function of state. A push occurs when host_valid & host_ready.
- Arbitration is evaluated every cycle, in priority order:
  1. force = (age == MAX_WAIT) & (fifo_count != 0) → grant host and pop the head; proc_stall = force.
  2. Otherwise, proc_we → grant the processor.
  3. Otherwise, a nonempty FIFO → grant host and pop.
  4. Otherwise, no grant.
- proc_stall depends only on registered state; there is no combinational path from any input. While stalled, the processor request is ignored and must be held unchanged by the processor.
- Age counter:
  - Cleared to 0 on any pop or when the FIFO is empty.
  - Otherwise increments by 1 each cycle, saturating at MAX_WAIT.
- Push and pop in the same cycle leave fifo_count unchanged. Read/write pointers wrap modulo DEPTH.
- A push to a full FIFO cannot occur, because host_ready is 0.
- Register 0 writes are granted and consumed (popped or accepted), but ctrl_writeEnable stays 0.
- Output stage:
  - On a grant of a non-suppressed write: register ctrl_writeEnable=1 and latch the granted reg/data.
  - On no grant or a suppressed write: ctrl_writeEnable=0, and ctrl_writeReg/data_writeReg hold their previous values.
- Reset (asynchronous, any time):
  - FIFO flushed, pointers and age set to 0.
  - Reset values: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, wr_err=0, fifo_count=0, proc_stall=0, host_ready=1.
  - Host entries buffered at reset are lost.

## Timing
- Processor write: proc_we sampled at edge N → ctrl_writeEnable high in cycle N..N+1 → regfile writes at edge N+1.
- Host write with an idle processor, accepted at edge N:
  - Popped at edge N+1.
  - ctrl_writeEnable high after N+1.
  - Regfile writes at edge N+2.
- Worst-case host wait: entry reaches the head, then MAX_WAIT cycles, then one forced grant. At most one stall cycle per MAX_WAIT+1 cycles while the FIFO stays nonempty under continuous proc_we.
- Throughput: one regfile write per cycle.

## Configuration
- REGFILE_WR_PROTECT_EN defined:
  - A granted write whose destination bit is set in PROT_MASK is consumed but suppressed (ctrl_writeEnable=0).
  - wr_err is set to 1 and stays 1 until reset.
  - Applies to both requesters.
- REGFILE_WR_PROTECT_EN undefined:
  - Only register 0 is suppressed.
  - PROT_MASK is ignored and wr_err is tied to 0.

## Test plan
- Reset mid-stream: FIFO holding 3 entries, assert ctrl_reset between edges → immediately fifo_count=0, ctrl_writeEnable=0, host_ready=1, wr_err=0; after release, no stale write appears.
- Processor path: proc_we=1, proc_reg=6, proc_data=32'h00001234 for one cycle → next cycle ctrl_writeEnable=1, ctrl_writeReg=6, data_writeReg=32'h00001234; the cycle after, ctrl_writeEnable=0.
- Starvation: proc_we held 1 continuously; push 4 host writes (regs 11–14) → host_ready=0 with fifo_count=4; proc_stall pulses for 1 cycle every MAX_WAIT+1=9 cycles; each host entry appears on the outputs in order 11, 12, 13, 14.
- Idle-processor host write: host push of reg 13 = 32'hAA at edge N → ctrl_writeEnable=1 with reg 13 / 32'hAA after edge N+1; simultaneous push+pop keeps fifo_count constant.
- Register 0: proc_we with proc_reg=0, then a host write to reg 0 → both consumed, ctrl_writeEnable stays 0, fifo_count returns to 0.
- Protection: host write to reg 3 = 32'h5 → with REGFILE_WR_PROTECT_EN: ctrl_writeEnable=0 and wr_err=1, held until reset; without the macro: reg 3 is written and wr_err=0.
